// File: rtl/pingpong_ctrl.sv
// pingpong_ctrl
// Self-sequencing ping-pong controller for two external single-port
// synchronous RAMs. One bank is filled from the write stream while the
// other bank is read out into a 2-entry output FIFO that feeds the read
// stream. The banks swap when the write bank is full and the read bank has
// no reads outstanding.
//
// Ports
//   clock_in            single clock for the controller and both RAMs
//   reset               synchronous, active-high reset
//   wr_valid/wr_ready   write stream handshake, wr_data write word
//   rd_valid/rd_ready   read stream handshake, rd_data read word (FIFO head)
//   a_add/b_add         bank addresses
//   a_wea/b_wea         bank write enables
//   a_din/b_din         bank write data (both carry wr_data)
//   a_dout/b_dout       bank read data, one-cycle read latency
//   ena                 RAM enable, constant 1
//   bank_sel            current write bank (0 = A, 1 = B)
//   swap_pulse          one-cycle pulse after each swap
module pingpong_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] a_add,
  output logic [ADDR_W-1:0] b_add,
  output logic              a_wea,
  output logic              b_wea,
  output logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] b_din,
  input  logic [DATA_W-1:0] a_dout,
  input  logic [DATA_W-1:0] b_dout,
  output logic              ena,
  output logic              bank_sel,
  output logic              swap_pulse
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic              r_bank_sel;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic              r_wr_full;
  logic [ADDR_W-1:0] r_rd_cnt;
  logic              r_rd_active;
  logic              r_rd_inflight;
  logic              r_swap_pulse;
  logic [DATA_W-1:0] r_fifo_mem [2];
  logic              r_fifo_wptr;
  logic              r_fifo_rptr;
  logic [1:0]        r_fifo_occ;

  logic              w_wr_fire;
  logic              w_pop;
  logic              w_push;
  logic [2:0]        w_credit;
  logic              w_rd_issue;
  logic              w_swap;
  logic [DATA_W-1:0] w_rd_dout;

  // Reset gating keeps the RAM write enables low while reset is asserted.
  assign w_wr_fire = wr_valid && !r_wr_full && !reset;
  assign w_pop     = (r_fifo_occ != 2'd0) && rd_ready;
  assign w_push    = r_rd_inflight;
  // Slots claimed after this edge: stored words plus the returning read,
  // less the word leaving now. Counting the departing word is what lets a
  // new read issue every cycle when the consumer keeps up.
  assign w_credit   = {1'b0, r_fifo_occ} + {2'b00, r_rd_inflight} - {2'b00, w_pop};
  assign w_rd_issue = r_rd_active && (w_credit < 3'd2) && !reset;
  assign w_swap     = r_wr_full && !r_rd_active && !r_rd_inflight;
  // No swap happens with a read in flight, so returning data always comes
  // from the bank opposite the current write bank.
  assign w_rd_dout  = r_bank_sel ? a_dout : b_dout;

  assign wr_ready   = !r_wr_full;
  assign rd_valid   = (r_fifo_occ != 2'd0);
  assign rd_data    = r_fifo_mem[r_fifo_rptr];
  assign a_din      = wr_data;
  assign b_din      = wr_data;
  assign ena        = 1'b1;
  assign bank_sel   = r_bank_sel;
  assign swap_pulse = r_swap_pulse;

  // Bank address/write-enable mux: write bank follows wr_cnt, read bank rd_cnt.
  always_comb begin
    a_add = '0;
    b_add = '0;
    a_wea = 1'b0;
    b_wea = 1'b0;
    if (r_bank_sel == 1'b0) begin
      a_add = r_wr_cnt;
      a_wea = w_wr_fire;
      b_add = r_rd_cnt;
      b_wea = 1'b0;
    end else begin
      b_add = r_wr_cnt;
      b_wea = w_wr_fire;
      a_add = r_rd_cnt;
      a_wea = 1'b0;
    end
  end

  // Bank sequencing, counters, read tracking and the output FIFO.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_bank_sel    <= 1'b0;
      r_wr_cnt      <= '0;
      r_wr_full     <= 1'b0;
      r_rd_cnt      <= '0;
      r_rd_active   <= 1'b0;
      r_rd_inflight <= 1'b0;
      r_swap_pulse  <= 1'b0;
      r_fifo_mem[0] <= '0;
      r_fifo_mem[1] <= '0;
      r_fifo_wptr   <= 1'b0;
      r_fifo_rptr   <= 1'b0;
      r_fifo_occ    <= 2'd0;
    end else begin
      r_swap_pulse <= w_swap;
      if (w_swap) begin
        r_bank_sel  <= ~r_bank_sel;
        r_wr_cnt    <= '0;
        r_wr_full   <= 1'b0;
        r_rd_cnt    <= '0;
        r_rd_active <= 1'b1;
      end else begin
        if (w_wr_fire) begin
          if (r_wr_cnt == LAST_IDX) begin
            r_wr_cnt  <= '0;
            r_wr_full <= 1'b1;
          end else begin
            r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
          end
        end
        // The last read retires the bank here; the in-flight flag holds the
        // swap off until its data has landed in the FIFO.
        if (w_rd_issue) begin
          if (r_rd_cnt == LAST_IDX) begin
            r_rd_cnt    <= '0;
            r_rd_active <= 1'b0;
          end else begin
            r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
          end
        end
      end
      r_rd_inflight <= w_rd_issue;
      if (w_push) begin
        r_fifo_mem[r_fifo_wptr] <= w_rd_dout;
        r_fifo_wptr             <= ~r_fifo_wptr;
      end
      if (w_pop) begin
        r_fifo_rptr <= ~r_fifo_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_occ <= r_fifo_occ + 2'd1;
        2'b01:   r_fifo_occ <= r_fifo_occ - 2'd1;
        default: r_fifo_occ <= r_fifo_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Directed bench for pingpong_ctrl: a DEPTH=16 instance for the main
// scenarios and a DEPTH=10 instance for the non-power-of-two wrap case.
// Behavioural single-port RAMs with one-cycle read latency sit on each bank.
module tb_pingpong_ctrl;

  logic clk;
  logic rst;

  // DEPTH=16 instance signals
  logic       wr_valid16, wr_ready16, rd_valid16, rd_ready16;
  logic [7:0] wr_data16, rd_data16;
  logic [3:0] a_add16, b_add16;
  logic       a_wea16, b_wea16, ena16, bank_sel16, swap_pulse16;
  logic [7:0] a_din16, b_din16, a_dout16, b_dout16;
  logic [7:0] mem_a16 [0:15];
  logic [7:0] mem_b16 [0:15];

  // DEPTH=10 instance signals
  logic       wr_valid10, wr_ready10, rd_valid10, rd_ready10;
  logic [7:0] wr_data10, rd_data10;
  logic [3:0] a_add10, b_add10;
  logic       a_wea10, b_wea10, ena10, bank_sel10, swap_pulse10;
  logic [7:0] a_din10, b_din10, a_dout10, b_dout10;
  logic [7:0] mem_a10 [0:15];
  logic [7:0] mem_b10 [0:15];

  int total = 0;
  int bad   = 0;

  logic [7:0] cap16[$];
  logic [7:0] cap10[$];
  logic       swaplog16[$];
  int         maxocc16;
  int         oor10;
  int         wr0_10;
  int         wr9_10;

  pingpong_ctrl #(.ADDR_W(4), .DEPTH(16), .DATA_W(8)) dut16 (
    .clock_in(clk), .reset(rst),
    .wr_valid(wr_valid16), .wr_ready(wr_ready16), .wr_data(wr_data16),
    .rd_valid(rd_valid16), .rd_ready(rd_ready16), .rd_data(rd_data16),
    .a_add(a_add16), .b_add(b_add16), .a_wea(a_wea16), .b_wea(b_wea16),
    .a_din(a_din16), .b_din(b_din16), .a_dout(a_dout16), .b_dout(b_dout16),
    .ena(ena16), .bank_sel(bank_sel16), .swap_pulse(swap_pulse16)
  );

  pingpong_ctrl #(.ADDR_W(4), .DEPTH(10), .DATA_W(8)) dut10 (
    .clock_in(clk), .reset(rst),
    .wr_valid(wr_valid10), .wr_ready(wr_ready10), .wr_data(wr_data10),
    .rd_valid(rd_valid10), .rd_ready(rd_ready10), .rd_data(rd_data10),
    .a_add(a_add10), .b_add(b_add10), .a_wea(a_wea10), .b_wea(b_wea10),
    .a_din(a_din10), .b_din(b_din10), .a_dout(a_dout10), .b_dout(b_dout10),
    .ena(ena10), .bank_sel(bank_sel10), .swap_pulse(swap_pulse10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: write-first not needed, read returns previous contents.
  always @(posedge clk) begin
    if (a_wea16) mem_a16[a_add16] <= a_din16;
    if (b_wea16) mem_b16[b_add16] <= b_din16;
    if (a_wea10) mem_a10[a_add10] <= a_din10;
    if (b_wea10) mem_b10[b_add10] <= b_din10;
    a_dout16 <= mem_a16[a_add16];
    b_dout16 <= mem_b16[b_add16];
    a_dout10 <= mem_a10[a_add10];
    b_dout10 <= mem_b10[b_add10];
  end

  // Monitors sample mid-cycle, when inputs and outputs are stable.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid16 && rd_ready16) cap16.push_back(rd_data16);
      if (rd_valid10 && rd_ready10) cap10.push_back(rd_data10);
      if (swap_pulse16) swaplog16.push_back(bank_sel16);
      if (int'(dut16.r_fifo_occ) > maxocc16) maxocc16 <= int'(dut16.r_fifo_occ);
      if ((a_add10 >= 4'd10) || (b_add10 >= 4'd10)) oor10 <= oor10 + 1;
      if ((a_wea10 && a_add10 == 4'd0) || (b_wea10 && b_add10 == 4'd0)) wr0_10 <= wr0_10 + 1;
      if ((a_wea10 && a_add10 == 4'd9) || (b_wea10 && b_add10 == 4'd9)) wr9_10 <= wr9_10 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  // Streams n words base, base+1, ... through the selected instance and
  // checks that exactly those words come out, in order.
  task automatic run_stream(input bit sel, input int n, input logic [7:0] base,
                            input bit rnd, input int budget, output int low_cnt);
    int  sent;
    int  cyc;
    int  got;
    bit  acc;
    bit  rdy;
    logic [7:0] w;
    sent = 0; cyc = 0; got = 0; low_cnt = 0;
    if (sel) cap10.delete(); else cap16.delete();
    while ((got < n) && (cyc < budget)) begin
      w = base + 8'(sent);
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sel) begin
        wr_valid10 = (sent < n); wr_data10 = w; rd_ready10 = rdy;
      end else begin
        wr_valid16 = (sent < n); wr_data16 = w; rd_ready16 = rdy;
      end
      #1;
      if (sel) begin
        acc = wr_valid10 && wr_ready10;
        if (!wr_ready10) low_cnt++;
      end else begin
        acc = wr_valid16 && wr_ready16;
        if (!wr_ready16) low_cnt++;
      end
      tick();
      if (acc) sent++;
      cyc++;
      got = sel ? cap10.size() : cap16.size();
    end
    wr_valid10 = 1'b0; wr_valid16 = 1'b0;
    rd_ready10 = 1'b1; rd_ready16 = 1'b1;
    repeat (6) tick();
    got = sel ? cap10.size() : cap16.size();
    chk(sel ? "d10_word_count" : "d16_word_count", 32'(got), 32'(n));
    for (int i = 0; (i < n) && (i < got); i++) begin
      chk(sel ? "d10_word" : "d16_word", sel ? 32'(cap10[i]) : 32'(cap16[i]),
          32'(8'(base + 8'(i))));
    end
  endtask

  initial begin
    int low;
    rst = 1'b1;
    wr_valid16 = 1'b0; wr_data16 = 8'h00; rd_ready16 = 1'b1;
    wr_valid10 = 1'b0; wr_data10 = 8'h00; rd_ready10 = 1'b1;
    maxocc16 = 0; oor10 = 0; wr0_10 = 0; wr9_10 = 0;
    repeat (3) tick();

    // Reset values
    chk("rst_bank_sel", 32'(bank_sel16), 32'h0);
    chk("rst_wr_ready", 32'(wr_ready16), 32'h1);
    chk("rst_rd_valid", 32'(rd_valid16), 32'h0);
    chk("rst_rd_data", 32'(rd_data16), 32'h0);
    chk("rst_swap_pulse", 32'(swap_pulse16), 32'h0);
    chk("rst_wea", 32'({a_wea16, b_wea16}), 32'h0);
    chk("rst_add", 32'({a_add16, b_add16}), 32'h0);
    chk("rst_ena", 32'(ena16), 32'h1);
    rst = 1'b0;

    // Single frame 0x00..0x0F, back-to-back, rd_ready = 1
    for (int i = 0; i < 16; i++) begin
      wr_valid16 = 1'b1;
      wr_data16  = 8'(i);
      #1;
      if (i == 0 || i == 9 || i == 15) begin
        chk("f1_a_wea", 32'(a_wea16), 32'h1);
        chk("f1_a_add", 32'(a_add16), 32'(i));
        chk("f1_b_wea", 32'(b_wea16), 32'h0);
      end
      tick();
    end
    wr_valid16 = 1'b0;
    chk("f1_full_ready", 32'(wr_ready16), 32'h0);
    chk("f1_no_swap_yet", 32'(swap_pulse16), 32'h0);
    tick();
    chk("f1_swap_pulse", 32'(swap_pulse16), 32'h1);
    chk("f1_bank_sel", 32'(bank_sel16), 32'h1);
    chk("f1_ready_back", 32'(wr_ready16), 32'h1);
    chk("f1_read_add", 32'(a_add16), 32'h0);
    tick();
    chk("f1_pulse_single", 32'(swap_pulse16), 32'h0);
    chk("f1_no_valid_yet", 32'(rd_valid16), 32'h0);
    tick();
    for (int k = 0; k < 16; k++) begin
      chk("f1_rd_valid", 32'(rd_valid16), 32'h1);
      chk("f1_rd_data", 32'(rd_data16), 32'(k));
      tick();
    end
    chk("f1_drained", 32'(rd_valid16), 32'h0);

    // Four streamed frames with continuous writes
    do_reset();
    swaplog16.delete();
    run_stream(1'b0, 64, 8'h00, 1'b0, 600, low);
    chk("stream_ready_low_cycles", 32'(low), 32'd7);
    chk("stream_swap_count", 32'(swaplog16.size()), 32'd4);
    for (int i = 0; (i < 4) && (i < swaplog16.size()); i++) begin
      chk("stream_bank_sel", 32'(swaplog16[i]), (i % 2 == 0) ? 32'h1 : 32'h0);
    end

    // Three frames with 50% read backpressure
    do_reset();
    maxocc16 = 0;
    run_stream(1'b0, 48, 8'h60, 1'b1, 2000, low);
    chk("bp_max_occupancy_le2", 32'(maxocc16 <= 2), 32'h1);

    // Reset after 7 of 16 writes
    do_reset();
    swaplog16.delete();
    for (int i = 0; i < 7; i++) begin
      wr_valid16 = 1'b1;
      wr_data16  = 8'hA0 + 8'(i);
      tick();
    end
    wr_data16 = 8'h40;
    rst = 1'b1;
    repeat (3) tick();
    chk("mid_rst_bank_sel", 32'(bank_sel16), 32'h0);
    chk("mid_rst_wr_ready", 32'(wr_ready16), 32'h1);
    chk("mid_rst_rd_valid", 32'(rd_valid16), 32'h0);
    chk("mid_rst_rd_data", 32'(rd_data16), 32'h0);
    chk("mid_rst_swap_pulse", 32'(swap_pulse16), 32'h0);
    chk("mid_rst_wea", 32'({a_wea16, b_wea16}), 32'h0);
    chk("mid_rst_add", 32'({a_add16, b_add16}), 32'h0);
    chk("mid_rst_ena", 32'(ena16), 32'h1);
    rst = 1'b0;
    #1;
    chk("post_rst_a_wea", 32'(a_wea16), 32'h1);
    chk("post_rst_a_add", 32'(a_add16), 32'h0);
    chk("post_rst_b_wea", 32'(b_wea16), 32'h0);
    chk("partial_no_swap", 32'(swaplog16.size()), 32'h0);
    run_stream(1'b0, 16, 8'h40, 1'b0, 200, low);

    // DEPTH=10 wrap over two frames
    do_reset();
    oor10 = 0; wr0_10 = 0; wr9_10 = 0;
    run_stream(1'b1, 20, 8'h80, 1'b0, 300, low);
    chk("d10_addr_out_of_range", 32'(oor10), 32'h0);
    chk("d10_writes_at_0", 32'(wr0_10), 32'd2);
    chk("d10_writes_at_9", 32'(wr9_10), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
